fp_addsub_seq: RTL and testbench

Multi-cycle IEEE-754-style floating-point add/subtract unit with parametrised exponent and mantissa widths.
- Handles both signs, aligns with a sticky right shift, normalises iteratively one bit per cycle, and detects special values.
- Sits beside the integer ALU and takes operands from the regfile read ports.
- Uses a valid/ready handshake so the pipeline can stall while a result is pending.

---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_align_shift.sv | 24 ++
 rtl/fp_addsub_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types, encodings and width/constant helpers for the sequential FP add/sub unit.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  function automatic int fp_word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // hidden + mantissa + guard + round + sticky
  function automatic int fp_sig_w(input int man_w);
    return man_w + 4;
  endfunction

  function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational right shifter that folds every shifted-out bit into the LSB (sticky).
module fp_align_shift #(
  parameter int SIG_W = 27,
  parameter int SH_W  = 8
) (
  input  logic [SIG_W-1:0] i_sig,
  input  logic [SH_W-1:0]  i_shamt,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] w_mask;
  logic [SIG_W-1:0] w_shifted;
  logic             w_sticky;

  // Bit gi is lost whenever the shift amount exceeds it; covers shifts >= SIG_W too.
  for (genvar gi = 0; gi < SIG_W; gi++) begin : g_mask
    assign w_mask[gi] = (int'(i_shamt) > gi);
  end

  assign w_shifted = i_sig >> i_shamt;
  assign w_sticky  = |(i_sig & w_mask);
  assign o_sig     = {w_shifted[SIG_W-1:1], w_shifted[0] | w_sticky};

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with valid/ready handshake and iterative normalise.
// Build option FP_ROUND_RNE_EN: round-to-nearest-even; otherwise truncate toward zero.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = fp_word_w(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] f1,
  input  logic [W-1:0] f2,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] f0,
  output logic [3:0]   flags
);

  localparam int SIG_W = fp_sig_w(MAN_W);
  localparam int EW1   = EXP_W + 1;
  localparam logic [W-1:0] QNAN    = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0] INF_MAG = W'(fp_inf(EXP_W, MAN_W));

  state_t r_state, w_state_next;

  logic [W-1:0]     r_a, r_b;
  logic             r_sign, r_sub;
  logic [EW1-1:0]   r_exp;
  logic [SIG_W-1:0] r_sig_a, r_sig_b;
  logic [SIG_W:0]   r_sum;
  logic [W-1:0]     r_f0;
  logic [3:0]       r_flags;

  // Operand unpack
  logic               w_sa, w_sb;
  logic [EXP_W-1:0]   w_ea, w_eb;
  logic [MAN_W-1:0]   w_ma, w_mb;
  logic               w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [SIG_W-1:0]   w_sig_a_full, w_sig_b_full;
  logic [W-2:0]       w_mag_a, w_mag_b;
  logic               w_swap;

  assign w_sa = r_a[W-1];
  assign w_sb = r_b[W-1];
  assign w_ea = r_a[W-2:MAN_W];
  assign w_eb = r_b[W-2:MAN_W];
  assign w_ma = r_a[MAN_W-1:0];
  assign w_mb = r_b[MAN_W-1:0];

  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_nan  = (w_ea == '1) && (w_ma != '0);
  assign w_b_nan  = (w_eb == '1) && (w_mb != '0);
  assign w_a_inf  = (w_ea == '1) && (w_ma == '0);
  assign w_b_inf  = (w_eb == '1) && (w_mb == '0);

  // Denormal mantissas are discarded so they behave exactly like zero.
  assign w_sig_a_full = w_a_zero ? '0 : {1'b1, w_ma, 3'b000};
  assign w_sig_b_full = w_b_zero ? '0 : {1'b1, w_mb, 3'b000};
  assign w_mag_a      = {w_ea, w_a_zero ? {MAN_W{1'b0}} : w_ma};
  assign w_mag_b      = {w_eb, w_b_zero ? {MAN_W{1'b0}} : w_mb};
  assign w_swap       = (w_mag_b > w_mag_a);

  logic             w_big_s, w_sml_s;
  logic [EXP_W-1:0] w_big_e, w_sml_e, w_shamt;
  logic [SIG_W-1:0] w_big_sig, w_sml_sig, w_sml_sig_sh;

  always_comb begin
    w_big_s   = w_sa;
    w_big_e   = w_ea;
    w_big_sig = w_sig_a_full;
    w_sml_s   = w_sb;
    w_sml_e   = w_eb;
    w_sml_sig = w_sig_b_full;
    if (w_swap) begin
      w_big_s   = w_sb;
      w_big_e   = w_eb;
      w_big_sig = w_sig_b_full;
      w_sml_s   = w_sa;
      w_sml_e   = w_ea;
      w_sml_sig = w_sig_a_full;
    end
  end

  assign w_shamt = w_big_e - w_sml_e;

  fp_align_shift #(
    .SIG_W (SIG_W),
    .SH_W  (EXP_W)
  ) u_align_shift (
    .i_sig   (w_sml_sig),
    .i_shamt (w_shamt),
    .o_sig   (w_sml_sig_sh)
  );

  logic         w_special;
  logic [W-1:0] w_spec_f0;
  logic [3:0]   w_spec_flags;

  always_comb begin
    w_special    = 1'b0;
    w_spec_f0    = '0;
    w_spec_flags = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
      w_special                  = 1'b1;
      w_spec_f0                  = QNAN;
      w_spec_flags[FLAG_INVALID] = 1'b1;
    end else if (w_a_inf) begin
      w_special = 1'b1;
      w_spec_f0 = {w_sa, INF_MAG[W-2:0]};
    end else if (w_b_inf) begin
      w_special = 1'b1;
      w_spec_f0 = {w_sb, INF_MAG[W-2:0]};
    end else if (w_a_zero && w_b_zero) begin
      w_special = 1'b1;
    end
  end

  logic [SIG_W:0] w_sum;
  logic           w_carry, w_hidden;

  assign w_sum    = r_sub ? ({1'b0, r_sig_a} - {1'b0, r_sig_b})
                          : ({1'b0, r_sig_a} + {1'b0, r_sig_b});
  assign w_carry  = r_sum[SIG_W];
  assign w_hidden = r_sum[SIG_W-1];

  // Rounding: mantissa incl. hidden bit sits above G, R, S.
  logic [MAN_W:0]   w_mant;
  logic             w_g, w_r, w_s, w_inexact, w_round_up;
  logic [MAN_W+1:0] w_mant_r;
  logic             w_mant_ovf;
  logic [MAN_W-1:0] w_mant_fin;
  logic [EW1-1:0]   w_exp_r;
  logic             w_exp_ovf;

  assign w_mant    = r_sum[SIG_W-1:3];
  assign w_g       = r_sum[2];
  assign w_r       = r_sum[1];
  assign w_s       = r_sum[0];
  assign w_inexact = w_g | w_r | w_s;
`ifdef FP_ROUND_RNE_EN
  assign w_round_up = w_g & (w_r | w_s | w_mant[0]);
`else
  assign w_round_up = 1'b0;
`endif
  assign w_mant_r   = {1'b0, w_mant} + (MAN_W+2)'(w_round_up);
  assign w_mant_ovf = w_mant_r[MAN_W+1];
  assign w_mant_fin = w_mant_ovf ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
  assign w_exp_r    = r_exp + EW1'(w_mant_ovf);
  assign w_exp_ovf  = (w_exp_r >= {1'b0, {EXP_W{1'b1}}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = ST_ALIGN;
      end
      ST_ALIGN: w_state_next = w_special ? ST_DONE : ST_ADD;
      ST_ADD:   w_state_next = (w_sum == '0) ? ST_DONE : ST_NORM;
      ST_NORM: begin
        if (w_carry || w_hidden)         w_state_next = ST_ROUND;
        else if (r_exp <= EW1'(1))       w_state_next = ST_DONE;
      end
      ST_ROUND: w_state_next = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_sub   <= 1'b0;
      r_exp   <= '0;
      r_sig_a <= '0;
      r_sig_b <= '0;
      r_sum   <= '0;
      r_f0    <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a <= f1;
            r_b <= {f2[W-1] ^ (op == OP_SUB), f2[W-2:0]};
          end
        end
        ST_ALIGN: begin
          r_sign  <= w_big_s;
          r_sub   <= w_big_s ^ w_sml_s;
          r_exp   <= {1'b0, w_big_e};
          r_sig_a <= w_big_sig;
          r_sig_b <= w_sml_sig_sh;
          if (w_special) begin
            r_f0    <= w_spec_f0;
            r_flags <= w_spec_flags;
          end
        end
        ST_ADD: begin
          r_sum <= w_sum;
          if (w_sum == '0) begin
            r_f0    <= '0;
            r_flags <= '0;
          end
        end
        ST_NORM: begin
          if (w_carry) begin
            r_sum <= {1'b0, r_sum[SIG_W:2], r_sum[1] | r_sum[0]};
            r_exp <= r_exp + EW1'(1);
          end else if (!w_hidden) begin
            if (r_exp <= EW1'(1)) begin
              r_f0                    <= '0;
              r_flags                 <= '0;
              r_flags[FLAG_UNDERFLOW] <= 1'b1;
            end else begin
              r_sum <= {r_sum[SIG_W-1:0], 1'b0};
              r_exp <= r_exp - EW1'(1);
            end
          end
        end
        ST_ROUND: begin
          r_flags <= '0;
          if (w_exp_ovf) begin
            r_f0                   <= {r_sign, INF_MAG[W-2:0]};
            r_flags[FLAG_OVERFLOW] <= 1'b1;
            r_flags[FLAG_INEXACT]  <= 1'b1;
          end else begin
            r_f0                  <= {r_sign, w_exp_r[EXP_W-1:0], w_mant_fin};
            r_flags[FLAG_INEXACT] <= w_inexact;
          end
        end
        default: ;
      endcase
    end
  end

  assign f0    = r_f0;
  assign flags = r_flags;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed-vector bench for fp_addsub_seq; expectations follow FP_ROUND_RNE_EN when defined.
module tb_fp_addsub_seq;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] f1 = '0;
  logic [W-1:0] f2 = '0;
  logic         op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] f0;
  logic [3:0]   flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_addsub_seq #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f1        (f1),
    .f2        (f2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f0        (f0),
    .flags     (flags)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    if (obs !== req) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, req);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
    @(negedge clk);
    f1 = a;
    f2 = b;
    op = o;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Cycles from the accept cycle (counted as 1) to the first cycle with out_valid.
  task automatic wait_result(output int lat);
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic o, input logic [W-1:0] req_f0, input logic [3:0] req_flags,
                         input int req_lat);
    int lat;
    launch(a, b, o);
    wait_result(lat);
    $display("TXN %s f1=%08h f2=%08h op=%0d -> f0=%08h flags=%04b lat=%0d",
             tag, a, b, o, f0, flags, lat);
    check_val({tag, "_f0"}, 64'(f0), 64'(req_f0));
    check_val({tag, "_flags"}, 64'(flags), 64'(req_flags));
    check_val({tag, "_lat"}, 64'(lat), 64'(req_lat));
    consume();
  endtask

  initial begin
    int lat;
    logic [W-1:0] rnd_f0;

    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_f0", 64'(f0), 64'd0);
    check_val("rst_flags", 64'(flags), 64'd0);
    rst_n = 1'b1;

    run_vec("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0, 5);
    run_vec("three_minus_two", 32'h40400000, 32'h40000000, 1'b1, 32'h3F800000, 4'h0, 6);
    run_vec("exact_zero", 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 4'h0, 3);
    run_vec("two_plus_neg3", 32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 4'h0, 6);
    run_vec("max_overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 5);
    run_vec("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 2);
    run_vec("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0, 2);
    run_vec("nan_in", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2);
    run_vec("zero_plus_negzero", 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0, 2);
`ifdef FP_ROUND_RNE_EN
    rnd_f0 = 32'h3F800002;
`else
    rnd_f0 = 32'h3F800001;
`endif
    run_vec("round_tie", 32'h3F800001, 32'h33800000, 1'b0, rnd_f0, 4'b0001, 5);
    run_vec("long_norm", 32'h3F800000, 32'hBF7FFFFF, 1'b0, 32'h33800000, 4'h0, 29);

    // Backpressure: result must hold while out_ready stays low.
    launch(32'h3F800000, 32'h3F800000, 1'b0);
    wait_result(lat);
    check_val("bp_lat", 64'(lat), 64'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("bp_hold_valid", 64'(out_valid), 64'd1);
      check_val("bp_hold_f0", 64'(f0), 64'h40000000);
      check_val("bp_hold_flags", 64'(flags), 64'd0);
      check_val("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    consume();
    @(negedge clk);
    $display("TXN backpressure f0=%08h out_valid=%0d in_ready=%0d", f0, out_valid, in_ready);
    check_val("bp_after_valid", 64'(out_valid), 64'd0);
    check_val("bp_after_in_ready", 64'(in_ready), 64'd1);

    // Reset while the long normalisation is still running.
    launch(32'h3F800000, 32'hBF7FFFFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_busy_valid", 64'(out_valid), 64'd0);
    check_val("mid_busy_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    $display("TXN reset_mid_norm out_valid=%0d in_ready=%0d", out_valid, in_ready);
    check_val("mid_rst_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_reset", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'h0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
